// File: rtl/rip_alu_arbiter.sv
// Two-requester arbiter in front of the shared registered-output ALU, with per-requester
// 2-entry response FIFOs and credit-limited issue. Define RIP_ALU_ARB_RR_EN for round-robin contention.
module rip_alu_arbiter #(
    parameter int PAYLOAD_W = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [PAYLOAD_W-1:0] req_payload0,
    input  logic [PAYLOAD_W-1:0] req_payload1,
    input  logic [1:0]           flush,
    output logic                 alu_issue,
    output logic [PAYLOAD_W-1:0] alu_payload,
    input  logic [31:0]          alu_rslt,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [31:0]          rsp_data0,
    output logic [31:0]          rsp_data1
);

    logic [1:0]       grant;
    logic [1:0]       eligible;
    logic [1:0]       infl;
    logic [1:0]       pop;
    logic             infl_vld;
    logic             infl_owner;
    logic [1:0][31:0] head;

    assign infl[0] = infl_vld & ~infl_owner;
    assign infl[1] = infl_vld & infl_owner;
    assign pop     = rsp_valid & rsp_ready;

`ifdef RIP_ALU_ARB_RR_EN
    // rr_ptr names the requester preferred on the next contention
    logic rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (|grant) begin
            rr_ptr <= grant[0];
        end
    end
`endif

    // Grant is gated by rst_n so req_ready reads 0 for the whole reset window
    always_comb begin
        grant = 2'b00;
        if (rst_n) begin
            case (eligible)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11: begin
`ifdef RIP_ALU_ARB_RR_EN
                    grant = rr_ptr ? 2'b10 : 2'b01;
`else
                    grant = 2'b01;
`endif
                end
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign alu_issue = |grant;

    always_comb begin
        alu_payload = '0;
        if (grant[0]) begin
            alu_payload = req_payload0;
        end else if (grant[1]) begin
            alu_payload = req_payload1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_vld   <= 1'b0;
            infl_owner <= 1'b0;
        end else begin
            infl_vld   <= |grant;
            infl_owner <= grant[1];
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_fifo
        logic [31:0] mem [2];
        logic        wr_ptr;
        logic        rd_ptr;
        logic [1:0]  occ;
        logic        push_i;
        logic        pop_i;

        // Flush drops both the captured result and anything still in the FIFO
        assign push_i = infl[i] & ~flush[i];
        assign pop_i  = pop[i] & ~flush[i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                occ    <= 2'd0;
            end else if (flush[i]) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                occ    <= 2'd0;
            end else begin
                if (push_i) begin
                    wr_ptr <= ~wr_ptr;
                end
                if (pop_i) begin
                    rd_ptr <= ~rd_ptr;
                end
                occ <= occ + {1'b0, push_i} - {1'b0, pop_i};
            end
        end

        always_ff @(posedge clk) begin
            if (push_i) begin
                mem[wr_ptr] <= alu_rslt;
            end
        end

        assign rsp_valid[i] = (occ != 2'd0);
        assign head[i]      = rsp_valid[i] ? mem[rd_ptr] : 32'd0;

        // Credit: results already queued or in flight, less this cycle's pop, must leave room
        assign eligible[i] = req_valid[i] & ~flush[i] &
                             (({1'b0, occ} + {2'b0, infl[i]}) < (3'd2 + {2'b0, pop[i]}));
    end

    assign rsp_data0 = head[0];
    assign rsp_data1 = head[1];

endmodule

// File: tb/tb_rip_alu_arbiter.sv
// Scoreboard bench for rip_alu_arbiter: expected ALU results queued on accept, compared on response pop.
module tb_rip_alu_arbiter;
    localparam int PW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req_valid = 2'b00;
    logic [1:0]    req_ready;
    logic [PW-1:0] p0 = '0;
    logic [PW-1:0] p1 = '0;
    logic [1:0]    flush = 2'b00;
    logic          alu_issue;
    logic [PW-1:0] alu_payload;
    logic [31:0]   alu_rslt = 32'd0;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready = 2'b00;
    logic [31:0]   rsp_data0;
    logic [31:0]   rsp_data1;

    int checks = 0;
    int errors = 0;
    int acc_cnt [2];
    int rsp_cnt [2];
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    logic [31:0] e0, e1;

    rip_alu_arbiter #(.PAYLOAD_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_payload0(p0), .req_payload1(p1), .flush(flush),
        .alu_issue(alu_issue), .alu_payload(alu_payload), .alu_rslt(alu_rslt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data0(rsp_data0), .rsp_data1(rsp_data1)
    );

    always #5 clk = ~clk;

    // ALU stand-in: registered add of the two low operand words
    always @(posedge clk) alu_rslt <= alu_payload[31:0] + alu_payload[63:32];

    function automatic logic [31:0] model(input logic [PW-1:0] p);
        return p[31:0] + p[63:32];
    endfunction

    function automatic logic [PW-1:0] mk(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r0, r1;
        r0 = $urandom();
        r1 = $urandom();
        return {r1, r0, b, a};
    endfunction

    // Scoreboard: accepts push, pops compare, flush/reset discard
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            if (flush[0]) begin
                exp_q0.delete();
            end else begin
                if (rsp_valid[0] && rsp_ready[0]) begin
                    checks++;
                    rsp_cnt[0]++;
                    if (exp_q0.size() == 0) begin
                        errors++;
                        $display("FAIL rsp0_unexpected got %h expected none", rsp_data0);
                    end else begin
                        e0 = exp_q0.pop_front();
                        if (rsp_data0 !== e0) begin
                            errors++;
                            $display("FAIL rsp0_data got %h expected %h", rsp_data0, e0);
                        end
                    end
                end
                if (req_valid[0] && req_ready[0]) begin
                    exp_q0.push_back(model(p0));
                    acc_cnt[0]++;
                end
            end
            if (flush[1]) begin
                exp_q1.delete();
            end else begin
                if (rsp_valid[1] && rsp_ready[1]) begin
                    checks++;
                    rsp_cnt[1]++;
                    if (exp_q1.size() == 0) begin
                        errors++;
                        $display("FAIL rsp1_unexpected got %h expected none", rsp_data1);
                    end else begin
                        e1 = exp_q1.pop_front();
                        if (rsp_data1 !== e1) begin
                            errors++;
                            $display("FAIL rsp1_data got %h expected %h", rsp_data1, e1);
                        end
                    end
                end
                if (req_valid[1] && req_ready[1]) begin
                    exp_q1.push_back(model(p1));
                    acc_cnt[1]++;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        flush = 2'b00;
        rsp_ready = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        p0 = mk(32'd1, 32'd2);
        p1 = mk(32'd5, 32'd6);
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if ({req_ready, alu_issue, rsp_valid} !== 5'b0) begin
                errors++;
                $display("FAIL reset_ctrl got rdy=%b iss=%b vld=%b expected 0", req_ready, alu_issue, rsp_valid);
            end
            checks++;
            if (alu_payload !== '0) begin
                errors++;
                $display("FAIL reset_payload got %h expected 0", alu_payload);
            end
            checks++;
            if ({rsp_data0, rsp_data1} !== 64'd0) begin
                errors++;
                $display("FAIL reset_data got %h %h expected 0", rsp_data0, rsp_data1);
            end
            @(posedge clk);
        end
        do_reset();
    endtask

    task automatic test_single();
        rsp_ready = 2'b11;
        p0 = mk(32'd3, 32'd4);
        req_valid = 2'b01;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01 || alu_issue !== 1'b1 || alu_payload !== p0) begin
            errors++;
            $display("FAIL single_issue got rdy=%b iss=%b pl=%h expected 01 1 %h", req_ready, alu_issue, alu_payload, p0);
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b00 || alu_issue !== 1'b0 || alu_payload !== '0) begin
            errors++;
            $display("FAIL single_t1 got vld=%b iss=%b pl=%h expected 00 0 0", rsp_valid, alu_issue, alu_payload);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b01 || rsp_data0 !== 32'h7) begin
            errors++;
            $display("FAIL single_t2 got vld=%b data=%h expected 01 00000007", rsp_valid, rsp_data0);
        end
        @(posedge clk);
        #1;
        idle(3);
    endtask

    task automatic test_contention();
        logic [1:0] exp_g;
        do_reset();
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            p0 = mk($urandom(), $urandom());
            p1 = mk($urandom(), $urandom());
`ifdef RIP_ALU_ARB_RR_EN
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            @(negedge clk);
            checks++;
            if (req_ready !== exp_g) begin
                errors++;
                $display("FAIL contention_grant%0d got %b expected %b", k, req_ready, exp_g);
            end
            checks++;
            if (alu_payload !== (exp_g[0] ? p0 : p1)) begin
                errors++;
                $display("FAIL contention_payload%0d got %h expected %h", k, alu_payload, exp_g[0] ? p0 : p1);
            end
            @(posedge clk);
            #1;
        end
        idle(4);
    endtask

    task automatic test_backpressure();
        int n_acc;
        do_reset();
        n_acc = 0;
        rsp_ready = 2'b01;
        req_valid = 2'b10;
        for (int k = 0; k < 5; k++) begin
            p1 = mk($urandom(), $urandom());
            @(negedge clk);
            if (req_ready[1]) n_acc++;
            checks++;
            if (req_ready[1] !== (k < 2)) begin
                errors++;
                $display("FAIL bp_ready%0d got %b expected %b", k, req_ready[1], k < 2);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (n_acc != 2) begin
            errors++;
            $display("FAIL bp_accepts got %0d expected 2", n_acc);
        end
        // FIFO full: pop re-opens issue in the same cycle, then push+pop keeps it streaming
        rsp_ready = 2'b11;
        for (int k = 0; k < 5; k++) begin
            p1 = mk($urandom(), $urandom());
            @(negedge clk);
            checks++;
            if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b1) begin
                errors++;
                $display("FAIL bp_stream%0d got rdy=%b vld=%b expected 1 1", k, req_ready[1], rsp_valid[1]);
            end
            @(posedge clk);
            #1;
        end
        idle(4);
    endtask

    task automatic issue0(input string tag);
        logic got;
        got = 1'b0;
        req_valid[0] = 1'b1;
        p0 = mk($urandom(), $urandom());
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            got = req_ready[0];
            @(posedge clk);
            #1 p1 = mk($urandom(), $urandom());
        end
        req_valid[0] = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout got no accept expected accept", tag);
        end
    endtask

    task automatic test_flush();
        int a1, r1;
        do_reset();
        a1 = acc_cnt[1];
        r1 = rsp_cnt[1];
        rsp_ready = 2'b10;
        req_valid = 2'b10;
        p1 = mk($urandom(), $urandom());
        issue0("flush_issue_a");
        issue0("flush_issue_b");
        flush = 2'b01;
        @(negedge clk);
        checks++;
        if (rsp_valid[0] !== 1'b1 || req_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL flush_cycle got vld0=%b rdy1=%b expected 1 1", rsp_valid[0], req_ready[1]);
        end
        @(posedge clk);
        #1 flush = 2'b00;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            p1 = mk($urandom(), $urandom());
            @(negedge clk);
            checks++;
            if (rsp_valid[0] !== 1'b0 || req_ready[1] !== 1'b1) begin
                errors++;
                $display("FAIL flush_after%0d got vld0=%b rdy1=%b expected 0 1", k, rsp_valid[0], req_ready[1]);
            end
            @(posedge clk);
            #1;
        end
        idle(4);
        checks++;
        if ((acc_cnt[1] - a1) != (rsp_cnt[1] - r1) || (acc_cnt[1] - a1) < 4) begin
            errors++;
            $display("FAIL flush_req1_count got acc=%0d rsp=%0d expected equal and >=4", acc_cnt[1] - a1, rsp_cnt[1] - r1);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        rsp_ready = 2'b11;
        p0 = mk($urandom(), $urandom());
        req_valid = 2'b01;
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, alu_issue, rsp_valid} !== 5'b0 || alu_payload !== '0 || {rsp_data0, rsp_data1} !== 64'd0) begin
            errors++;
            $display("FAIL areset_outputs got rdy=%b iss=%b vld=%b expected all 0", req_ready, alu_issue, rsp_valid);
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL areset_stale%0d got vld=%b rdy=%b expected 00 00", k, rsp_valid, req_ready);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        acc_cnt = '{0, 0};
        rsp_cnt = '{0, 0};
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_flush();
        test_async_reset();
        idle(4);
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL lost_results got %0d %0d pending expected 0 0", exp_q0.size(), exp_q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rip_alu_arbiter.md
# rip_alu_arbiter

Shares the single registered-output integer ALU between two requesters: requester 0 is the core execute stage, requester 1 is the reservoir update engine. It arbitrates valid/ready requests, drives one operation per cycle into the ALU, and tracks which requester owns each in-flight result. Results are returned through per-requester 2-entry response FIFOs, so issue is credit-limited and never drops a result.

## Interface
- `PAYLOAD_W`, 128: width of the opaque operation bundle (decoded inst, rs1, rs2, pc, csr, imm, zimm) forwarded to the ALU.
- `clk` input 1: the block's single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input 2: request valid, bit i = requester i.
- `req_ready` output 2: request accepted when `req_valid[i] & req_ready[i]`.
- `req_payload0` input PAYLOAD_W: operation bundle of requester 0.
- `req_payload1` input PAYLOAD_W: operation bundle of requester 1.
- `flush` input 2: synchronous per-requester discard of queued and in-flight results.
- `alu_issue` output 1: an operation is presented to the ALU this cycle.
- `alu_payload` output PAYLOAD_W: bundle of the granted requester; all-zero when `alu_issue`=0.
- `alu_rslt` input 32: registered ALU result, valid the cycle after issue.
- `rsp_valid` output 2: response FIFO i non-empty.
- `rsp_ready` input 2: response consumed when `rsp_valid[i] & rsp_ready[i]`.
- `rsp_data0` output 32: head of response FIFO 0.
- `rsp_data1` output 32: head of response FIFO 1.

## Operation
- Per requester i: `occ[i]` (0..2) is FIFO occupancy. `infl[i]` is 1 if an op for i was issued last cycle.
- `pop[i] = rsp_valid[i] & rsp_ready[i]`.
- Requester i is eligible when `req_valid[i] & !flush[i] & (occ[i] + infl[i] - pop[i] < 2)`.
- Grant policy:
  - Only one eligible requester: it wins.
  - Both eligible: the policy in Configuration decides.
- `req_ready[i]` = grant[i]; at most one bit is set per cycle.
- `alu_issue` = |grant. `alu_payload` = the granted payload, combinational mux.
- Capture stage:
  - Register `infl` and the owner index on each issue.
  - In the following cycle, write `alu_rslt` into the owner's FIFO unless `flush[owner]` is asserted that cycle.
- FIFO i is 2 entries with wrap-around read/write pointers.
  - Push and pop in the same cycle are legal at any occupancy, including full: occ stays unchanged and data order is preserved.
  - Overflow is impossible by the credit rule.
- `flush[i]`:
  - Empties FIFO i: pointers and occ cleared.
  - Cancels `infl[i]`, so the in-flight result is dropped.
  - Blocks grant to i for that cycle.
  - Requester 1−i is unaffected.
  - Flush wins over a simultaneous push, pop or request.
- Reset (asynchronous, any time, including mid-operation):
  - FIFOs emptied, `infl` cleared, round-robin pointer set to 0.
  - Any in-flight result is discarded.
- Reset value of every output while and after `rst_n` is low: `req_ready`=0, `alu_issue`=0, `alu_payload`=0, `rsp_valid`=0, `rsp_data0`=0, `rsp_data1`=0.

## Timing
- Cycle t: request accepted, `alu_issue`=1. The ALU registers its result at the end of t.
- Cycle t+1: `alu_rslt` valid; captured into the FIFO at the end of t+1.
- Cycle t+2: `rsp_valid[i]`=1. Request-to-response latency is 2 cycles.
- Throughput: one issue per cycle total.
  - A single requester sustains one op/cycle while it holds `rsp_ready`=1.
  - With `rsp_ready`=0 it stalls after 2 outstanding ops.
- `req_ready` depends combinationally on `req_valid`, `flush`, `rsp_ready` and state. No other input-to-output combinational paths.
- `rsp_data` is a registered FIFO head.

## Configuration
- `RIP_ALU_ARB_RR_EN` defined: round-robin.
  - On contention, grant the requester not granted most recently.
  - The pointer updates on every grant.
- `RIP_ALU_ARB_RR_EN` undefined:
  - Fixed priority, requester 0 always wins contention.
  - No pointer state exists.

## Test plan
- Reset, then single op: requester 0 issues add with payload yielding `alu_rslt`=0x0000_0007 at cycle t. Required: `rsp_valid[0]`=1 with `rsp_data0`=0x7 at t+2; `rsp_valid[1]` stays 0.
- Contention, both requesters valid for 4 cycles, all `rsp_ready`=1:
  - With RR_EN: grants 0,1,0,1.
  - Without RR_EN: grants 0,0,0,0 and `req_ready[1]` stays 0.
- Backpressure: requester 1 streams with `rsp_ready[1]`=0.
  - Exactly 2 accepts, then `req_ready[1]`=0.
  - Raising `rsp_ready[1]` pops results in issue order and re-opens issue the same cycle.
- Full FIFO with push and pop same cycle: occ stays 2 and data order is intact.
- Flush: assert `flush[0]` the cycle after a requester-0 issue while FIFO 0 holds 1 entry.
  - FIFO 0 empties and the in-flight result is never delivered.
  - Requester 1 traffic continues unchanged.
- Async reset: drop `rst_n` mid-stream with one op in flight. Required: all outputs 0 immediately, and no stale response after release.
